// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
// Raster scan generator and DAC output stage for the Pacman display path.
// A divide-by-two toggle produces the pixel tick, h/v counters sweep the
// frame, and sync/blank travel down a short delay line so they leave the
// block on the same pixel tick as the color returned for that coordinate.
//
// Handshake: there is no valid/ready pair here. The coordinate is presented
// on x_vga/y_vga after every pix_en tick, and the system must hold the matching
// color on color_vga exactly PIPE_LAT ticks later. Nothing can stall the scan.
// PIPE_LAT must be in the range 1..4.

module vga_scan_ctrl #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int PIPE_LAT  = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    output logic       VGA_CLK,
    output logic       pix_en,
    output logic [9:0] x_vga,
    output logic [9:0] y_vga,
    output logic       active,
    input  logic [2:0] color_vga,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_start
);

    localparam logic [9:0] H_MAX    = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_MAX    = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_VISIBLE);
    localparam logic [9:0] V_ACT    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    // Delay-line entry layout: {hs, vs, blank}; idle value is blank with
    // both syncs inactive (high).
    localparam logic [2:0] DLY_IDLE = 3'b111;

    logic       t;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs_raw;
    logic       vs_raw;
    logic       blank_raw;
    logic [PIPE_LAT:0][2:0] dly;

    // Divide-by-two toggle; its high phase is the pixel tick.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) t <= 1'b0;
        else       t <= ~t;
    end

    assign VGA_CLK    = t;
    assign pix_en     = t;
    assign x_vga      = h;
    assign y_vga      = v;
    assign VGA_SYNC_N = 1'b0;
    assign active     = (h < H_ACT) && (v < V_ACT);

    // Horizontal and vertical scan counters, advancing on the pixel tick.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            if (h == H_MAX) begin
                h <= '0;
                v <= (v == V_MAX) ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // One-cycle pulse in the cycle right after the frame wraps to (0,0).
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) frame_start <= 1'b0;
        else       frame_start <= pix_en && (h == H_MAX) && (v == V_MAX);
    end

    // Undelayed sync/blank decode of the current coordinate.
    always_comb begin
        hs_raw    = 1'b1;
        vs_raw    = 1'b1;
        blank_raw = 1'b0;
        if (h >= HS_START && h <= HS_END) hs_raw = 1'b0;
        if (v >= VS_START && v <= VS_END) vs_raw = 1'b0;
        if (h >= H_ACT || v >= V_ACT)     blank_raw = 1'b1;
    end

    // Sync/blank delay line; its last stage drives the pins directly.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)       dly <= {(PIPE_LAT + 1){DLY_IDLE}};
        else if (pix_en) dly <= {dly[PIPE_LAT-1:0], {hs_raw, vs_raw, blank_raw}};
    end

    assign VGA_HS      = dly[PIPE_LAT][2];
    assign VGA_VS      = dly[PIPE_LAT][1];
    assign VGA_BLANK_N = ~dly[PIPE_LAT][0];

    // Color capture and RGB expansion. The blank bit used here is the one
    // moving into the final delay stage on this same tick, so color and
    // blank leave together. During blanking the color input is never looked
    // at, so an unknown color cannot reach the pins.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            VGA_R <= 8'h00;
            VGA_G <= 8'h00;
            VGA_B <= 8'h00;
        end else if (pix_en) begin
            if (dly[PIPE_LAT-1][0]) begin
                VGA_R <= 8'h00;
                VGA_G <= 8'h00;
                VGA_B <= 8'h00;
            end else begin
                VGA_R <= color_vga[2] ? 8'hFF : 8'h00;
                VGA_G <= color_vga[1] ? 8'hFF : 8'h00;
                VGA_B <= color_vga[0] ? 8'hFF : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: a full-size instance (a) for line timing, color
// latency and horizontal blanking, and a shrunken-geometry instance (b) for
// frame-level behaviour (vertical sync/blank, frame_start period).
`timescale 1ns/1ps

module tb_vga_scan_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #10 clk = ~clk;

    // ---------------- instance a (640x480) ----------------
    logic       vclk_a, pix_en_a, active_a, hs_a, vs_a, blank_n_a, sync_n_a, fs_a;
    logic [9:0] x_a, y_a;
    logic [7:0] r_a, g_a, b_a;
    logic [2:0] color_a;

    vga_scan_ctrl u_dut_a (
        .CLOCK_50(clk), .reset(rst_a), .VGA_CLK(vclk_a), .pix_en(pix_en_a),
        .x_vga(x_a), .y_vga(y_a), .active(active_a), .color_vga(color_a),
        .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_HS(hs_a), .VGA_VS(vs_a),
        .VGA_BLANK_N(blank_n_a), .VGA_SYNC_N(sync_n_a), .frame_start(fs_a)
    );

    // ---------------- instance b (8x6 visible, 15x10 total) ----------------
    logic       vclk_b, pix_en_b, active_b, hs_b, vs_b, blank_n_b, sync_n_b, fs_b;
    logic [9:0] x_b, y_b;
    logic [7:0] r_b, g_b, b_b;
    logic [2:0] color_b;
    assign color_b = 3'b111;

    vga_scan_ctrl #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_LAT(2)
    ) u_dut_b (
        .CLOCK_50(clk), .reset(rst_b), .VGA_CLK(vclk_b), .pix_en(pix_en_b),
        .x_vga(x_b), .y_vga(y_b), .active(active_b), .color_vga(color_b),
        .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
        .VGA_BLANK_N(blank_n_b), .VGA_SYNC_N(sync_n_b), .frame_start(fs_b)
    );

    // ---------------- color source model for instance a ----------------
    // Returns the color for the coordinate presented two ticks earlier.
    // mode 0: 3'b101 for x=100 only; mode 1: constant 3'b111;
    // mode 2: 3'b111 for visible x, unknown for x>=640.
    int         mode = 0;
    logic [9:0] xd1 = '0;
    logic [9:0] xd2 = '0;

    always @(posedge clk) begin
        if (pix_en_a) begin
            xd1 <= x_a;
            xd2 <= xd1;
        end
    end

    always_comb begin
        color_a = 3'b000;
        case (mode)
            0:       color_a = (xd2 == 10'd100) ? 3'b101 : 3'b000;
            1:       color_a = 3'b111;
            default: color_a = (xd2 >= 10'd640) ? 3'bxxx : 3'b111;
        endcase
    end

    // ---------------- scoreboard counters / checker ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- driver / wait tasks ----------------
    // One pixel tick = two CLOCK_50 cycles; sampling is always at negedge.
    task automatic ticks(input int n);
        repeat (2 * n) @(negedge clk);
    endtask

    // Stop at the first negedge after instance a presents (xx,yy).
    task automatic wait_a(input logic [9:0] xx, input logic [9:0] yy, input string tag);
        int  c;
        logic found;
        c = 0;
        found = 1'b0;
        while (c < 4000 && !found) begin
            @(negedge clk);
            c++;
            if (x_a == xx && y_a == yy && !pix_en_a) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_b(input logic [9:0] xx, input logic [9:0] yy, input string tag);
        int  c;
        logic found;
        c = 0;
        found = 1'b0;
        while (c < 400 && !found) begin
            @(negedge clk);
            c++;
            if (x_b == xx && y_b == yy && !pix_en_b) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        logic found;

        // Reset values, sampled mid-reset.
        #105;
        check("rst_vclk",    32'(vclk_a), 32'd0);
        check("rst_pix_en",  32'(pix_en_a), 32'd0);
        check("rst_x",       32'(x_a), 32'd0);
        check("rst_y",       32'(y_a), 32'd0);
        check("rst_active",  32'(active_a), 32'd1);
        check("rst_rgb",     32'({r_a, g_a, b_a}), 32'h0);
        check("rst_hs",      32'(hs_a), 32'd1);
        check("rst_vs",      32'(vs_a), 32'd1);
        check("rst_blank_n", 32'(blank_n_a), 32'd0);
        check("rst_sync_n",  32'(sync_n_a), 32'd0);
        check("rst_fs",      32'(fs_a), 32'd0);
        check("rst_b_vs",    32'(vs_b), 32'd1);
        #100;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Pixel clock and first coordinate steps.
        @(negedge clk);
        check("start_vclk0", 32'(vclk_a), 32'd1);
        check("start_pix0",  32'(pix_en_a), 32'd1);
        check("start_x0",    32'(x_a), 32'd0);
        @(negedge clk);
        check("start_vclk1", 32'(vclk_a), 32'd0);
        check("start_x1",    32'(x_a), 32'd1);
        @(negedge clk);
        check("start_vclk2", 32'(vclk_a), 32'd1);
        check("start_x1b",   32'(x_a), 32'd1);
        @(negedge clk);
        check("start_x2",    32'(x_a), 32'd2);

        // Color latency: 3'b101 for x=100 appears 3 ticks later, one tick wide.
        wait_a(10'd100, 10'd0, "wait_x100");
        ticks(2);
        check("lat_before", 32'({r_a, g_a, b_a}), 32'h000000);
        ticks(1);
        check("lat_hit",    32'({r_a, g_a, b_a}), 32'hFF00FF);
        ticks(1);
        check("lat_after",  32'({r_a, g_a, b_a}), 32'h000000);
        mode = 1;

        // HSYNC: falls 3 ticks after x=656, low for 96 ticks.
        wait_a(10'd656, 10'd0, "wait_x656");
        ticks(2);
        check("hs_pre",   32'(hs_a), 32'd1);
        ticks(1);
        check("hs_fall",  32'(hs_a), 32'd0);
        check("hs_blank", 32'(blank_n_a), 32'd0);
        ticks(95);
        check("hs_last",  32'(hs_a), 32'd0);
        ticks(1);
        check("hs_rise",  32'(hs_a), 32'd1);

        // Line wrap.
        wait_a(10'd798, 10'd0, "wait_x798");
        ticks(1);
        check("wrap_x799",    32'(x_a), 32'd799);
        check("wrap_y0",      32'(y_a), 32'd0);
        check("wrap_act799",  32'(active_a), 32'd0);
        ticks(1);
        check("wrap_x0",      32'(x_a), 32'd0);
        check("wrap_y1",      32'(y_a), 32'd1);
        check("wrap_act0",    32'(active_a), 32'd1);

        // Horizontal blanking with constant white.
        wait_a(10'd637, 10'd1, "wait_x637");
        ticks(3);
        check("hb_637_rgb", 32'({r_a, g_a, b_a}), 32'hFFFFFF);
        check("hb_637_bn",  32'(blank_n_a), 32'd1);
        ticks(2);
        check("hb_639_rgb", 32'({r_a, g_a, b_a}), 32'hFFFFFF);
        ticks(1);
        check("hb_640_rgb", 32'({r_a, g_a, b_a}), 32'h000000);
        check("hb_640_bn",  32'(blank_n_a), 32'd0);
        mode = 2;

        // Unknown color during blanking must not reach the pins.
        wait_a(10'd636, 10'd2, "wait_x636");
        ticks(3);
        for (int k = 0; k < 8; k++) begin
            check("xb_rgb", 32'({r_a, g_a, b_a}), (636 + k < 640) ? 32'hFFFFFF : 32'h000000);
            check("xb_bn",  32'(blank_n_a), (636 + k < 640) ? 32'd1 : 32'd0);
            ticks(1);
        end

        // Mid-frame reset clears outputs immediately.
        wait_a(10'd300, 10'd3, "wait_x300");
        check("mr_pre_rgb", 32'({r_a, g_a, b_a}), 32'hFFFFFF);
        #5 rst_a = 1'b1;
        #1;
        check("mr_x",       32'(x_a), 32'd0);
        check("mr_y",       32'(y_a), 32'd0);
        check("mr_rgb",     32'({r_a, g_a, b_a}), 32'h000000);
        check("mr_blank_n", 32'(blank_n_a), 32'd0);
        check("mr_hs",      32'(hs_a), 32'd1);
        @(negedge clk);
        #5 rst_a = 1'b0;
        @(negedge clk);
        check("mr_restart_x0", 32'(x_a), 32'd0);
        @(negedge clk);
        check("mr_restart_x1", 32'(x_a), 32'd1);
        check("mr_restart_y0", 32'(y_a), 32'd0);

        // ---- instance b: frame_start width and period ----
        c = 0;
        found = 1'b0;
        while (c < 400 && !found) begin
            @(negedge clk);
            c++;
            if (fs_b) found = 1'b1;
        end
        check("fs_seen", 32'(found), 32'd1);
        check("fs_x0",   32'(x_b), 32'd0);
        check("fs_y0",   32'(y_b), 32'd0);
        @(negedge clk);
        check("fs_width", 32'(fs_b), 32'd0);
        c = 1;
        found = 1'b0;
        while (c < 400 && !found) begin
            @(negedge clk);
            c++;
            if (fs_b) found = 1'b1;
        end
        check("fs_period", 32'(c), 32'd300);

        // Vertical blanking with constant white.
        wait_b(10'd7, 10'd5, "wait_b_7_5");
        check("vb_act_in", 32'(active_b), 32'd1);
        ticks(3);
        check("vb_in_rgb", 32'({r_b, g_b, b_b}), 32'hFFFFFF);
        check("vb_in_bn",  32'(blank_n_b), 32'd1);
        wait_b(10'd0, 10'd6, "wait_b_0_6");
        check("vb_act_out", 32'(active_b), 32'd0);
        ticks(3);
        check("vb_out_rgb", 32'({r_b, g_b, b_b}), 32'h000000);
        check("vb_out_bn",  32'(blank_n_b), 32'd0);

        // VSYNC low for lines 7..8, shifted by 3 ticks.
        wait_b(10'd0, 10'd7, "wait_b_0_7");
        ticks(2);
        check("vs_pre",  32'(vs_b), 32'd1);
        ticks(1);
        check("vs_fall", 32'(vs_b), 32'd0);
        wait_b(10'd14, 10'd8, "wait_b_14_8");
        ticks(3);
        check("vs_last", 32'(vs_b), 32'd0);
        ticks(1);
        check("vs_rise", 32'(vs_b), 32'd1);

        // Frame wrap (14,9) -> (0,0).
        wait_b(10'd14, 10'd9, "wait_b_14_9");
        ticks(1);
        check("fwrap_x", 32'(x_b), 32'd0);
        check("fwrap_y", 32'(y_b), 32'd0);

        // Mid-frame reset on b.
        wait_b(10'd5, 10'd4, "wait_b_5_4");
        #5 rst_b = 1'b1;
        #1;
        check("mrb_x",   32'(x_b), 32'd0);
        check("mrb_y",   32'(y_b), 32'd0);
        check("mrb_rgb", 32'({r_b, g_b, b_b}), 32'h000000);
        @(negedge clk);
        #5 rst_b = 1'b0;
        repeat (2) @(negedge clk);
        check("mrb_restart_x1", 32'(x_b), 32'd1);

        // ---- final report ----
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
